// File: rtl/amo_arbiter_pkg.sv
// Shared definitions for the AMO arbiter and the downstream atomic unit.
// Holds the arbiter FSM state encoding and the RISC-V AMO funct5 codes.
package amo_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StBusy  = 2'd2,
    StGap   = 2'd3
  } arb_state_e;

  // AMO operation codes (funct5)
  localparam logic [4:0] AmoAdd  = 5'b00000;
  localparam logic [4:0] AmoSwap = 5'b00001;
  localparam logic [4:0] AmoLr   = 5'b00010;
  localparam logic [4:0] AmoSc   = 5'b00011;
  localparam logic [4:0] AmoXor  = 5'b00100;
  localparam logic [4:0] AmoOr   = 5'b01000;
  localparam logic [4:0] AmoAnd  = 5'b01100;
  localparam logic [4:0] AmoMin  = 5'b10000;
  localparam logic [4:0] AmoMax  = 5'b10100;
  localparam logic [4:0] AmoMinu = 5'b11000;
  localparam logic [4:0] AmoMaxu = 5'b11100;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: scans req_i starting at ptr_i, wrapping modulo CORE_NUMS,
// and returns the first requester found.
//   req_i   : request vector
//   ptr_i   : index where the search starts
//   gnt_o   : one-hot grant (all zero when nothing requested)
//   idx_o   : binary index of the granted requester
//   valid_o : at least one request present
module rr_picker #(
  parameter int unsigned CORE_NUMS      = 4,
  parameter int unsigned CORE_NUMS_BITS = 2
) (
  input  logic [CORE_NUMS-1:0]      req_i,
  input  logic [CORE_NUMS_BITS-1:0] ptr_i,
  output logic [CORE_NUMS-1:0]      gnt_o,
  output logic [CORE_NUMS_BITS-1:0] idx_o,
  output logic                      valid_o
);

  int unsigned              cand;
  logic [CORE_NUMS_BITS-1:0] cand_idx;

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    gnt_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < CORE_NUMS; k++) begin
      cand     = (32'(ptr_i) + k) % CORE_NUMS;
      cand_idx = cand[CORE_NUMS_BITS-1:0];
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
    if (valid_o) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/amo_arbiter.sv
// Round-robin arbiter that serialises per-core atomic requests onto a single
// shared atomic unit. One request is in flight at a time; each transaction
// walks IDLE -> ISSUE -> BUSY -> GAP so downstream strobes are always separated
// by at least one idle cycle for the CDC synchronizer.
//   core_*_i      : per-core request fields (strobe is a one-cycle pulse)
//   core_done_o   : one-hot completion pulse to the granted core
//   core_data_o   : result data, broadcast, valid with a done pulse
//   S_*_o         : request to the atomic unit, muxed from the registered grant
//   S_done_i/S_data_i : completion from the atomic unit
//   busy_o        : FSM not idle; err_o : sticky protocol error
module amo_arbiter
  import amo_arbiter_pkg::*;
#(
  parameter int unsigned CORE_NUMS      = 4,
  parameter int unsigned CORE_NUMS_BITS = 2,
  parameter int unsigned XLEN           = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [CORE_NUMS-1:0]        core_strobe_i,
  input  logic [CORE_NUMS*XLEN-1:0]   core_addr_i,
  input  logic [CORE_NUMS*XLEN-1:0]   core_data_i,
  input  logic [CORE_NUMS-1:0]        core_rw_i,
  input  logic [CORE_NUMS-1:0]        core_is_amo_i,
  input  logic [CORE_NUMS*5-1:0]      core_amo_type_i,
  output logic [CORE_NUMS-1:0]        core_done_o,
  output logic [XLEN-1:0]             core_data_o,
  output logic                        S_strobe_o,
  output logic                        S_rw_o,
  output logic                        S_is_amo_o,
  output logic [CORE_NUMS_BITS-1:0]   S_core_id_o,
  output logic [XLEN-1:0]             S_addr_o,
  output logic [XLEN-1:0]             S_data_o,
  output logic [4:0]                  S_amo_type_o,
  input  logic                        S_done_i,
  input  logic [XLEN-1:0]             S_data_i,
  output logic                        busy_o,
  output logic                        err_o
);

  arb_state_e                state_q, state_d;
  logic [CORE_NUMS-1:0]      pending_q, pending_d;
  logic [CORE_NUMS_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [CORE_NUMS_BITS-1:0] grant_q, grant_d;
  logic                      err_q, err_d;

  logic [CORE_NUMS-1:0]      grant_oh;
  logic [CORE_NUMS-1:0]      active_oh;
  logic [CORE_NUMS-1:0]      strobe_ok;
  logic [CORE_NUMS-1:0]      req_vec;
  logic [CORE_NUMS-1:0]      pick_oh;
  logic [CORE_NUMS_BITS-1:0] pick_idx;
  logic                      pick_valid;

  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
  end

  // The granted core is "in flight" until its done cycle; in the done cycle
  // a fresh strobe from it is a legal new request.
  assign active_oh = ((state_q == StIssue) || ((state_q == StBusy) && !S_done_i)) ?
                     grant_oh : '0;
  assign strobe_ok = core_strobe_i & ~pending_q & ~active_oh;
  // Same-cycle strobes join the search directly so they cost no extra latency.
  assign req_vec   = pending_q | strobe_ok;

  rr_picker #(
    .CORE_NUMS      (CORE_NUMS),
    .CORE_NUMS_BITS (CORE_NUMS_BITS)
  ) u_rr_picker (
    .req_i   (req_vec),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_oh),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | strobe_ok;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    err_d     = err_q | (|(core_strobe_i & ~strobe_ok)) | (S_done_i && (state_q != StBusy));

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d   = pick_idx;
          rr_ptr_d  = (pick_idx == CORE_NUMS_BITS'(CORE_NUMS - 1)) ? '0 : pick_idx + 1'b1;
          pending_d = req_vec & ~pick_oh;
          state_d   = StIssue;
        end
      end
      StIssue: state_d = StBusy;
      StBusy:  if (S_done_i) state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      err_q     <= err_d;
    end
  end

  assign S_strobe_o   = (state_q == StIssue);
  assign busy_o       = (state_q != StIdle);
  assign err_o        = err_q;
  assign core_done_o  = ((state_q == StBusy) && S_done_i) ? grant_oh : '0;
  assign core_data_o  = S_data_i;

  assign S_core_id_o  = grant_q;
  assign S_addr_o     = core_addr_i[grant_q*XLEN +: XLEN];
  assign S_data_o     = core_data_i[grant_q*XLEN +: XLEN];
  assign S_rw_o       = core_rw_i[grant_q];
  assign S_is_amo_o   = core_is_amo_i[grant_q];
  assign S_amo_type_o = core_amo_type_i[grant_q*5 +: 5];

endmodule
